// File: rtl/mem_access_seq.sv
`timescale 1ns/1ps
// mem_access_seq
// Multi-cycle sequencer between the control decoder and the data RAM.
// It accepts one load/store request at a time and drives the RAM
// handshake: ram_mov goes out and ram_moc comes back. It steers
// big-endian byte lanes, sign/zero-extends loads, and holds the core
// (stall) until the access finishes. Misaligned, bad-size and timed-out
// accesses finish with err set and a cause code.
//
// Parameters
//   TIMEOUT  cycles in ACCESS without ram_moc before abort (>=2)
//   AW       address width
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start              request strobe, sampled in IDLE only
//   rw                 1=load, 0=store
//   size               00=byte, 01=half, 10=word, 11=reserved
//   unsigned_ld        1=zero-extend load, 0=sign-extend
//   addr, wdata        byte address, right-justified store data
//   ram_moc, ram_rdata RAM completion and read word
//   ram_mov, ram_rw    RAM request strobe and direction (registered)
//   ram_addr, ram_be   word-aligned address and byte enables (be[3]=MSB lane)
//   ram_wdata          lane-replicated store data
//   stall              hold PC/pipeline
//   done               one-cycle completion pulse
//   rdata              extended load result (valid with done & !err)
//   err, err_code      abort flag and cause: 01 misaligned, 10 timeout, 11 bad size

module mem_access_seq #(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          rw,
    input  logic [1:0]    size,
    input  logic          unsigned_ld,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic          ram_moc,
    input  logic [31:0]   ram_rdata,
    output logic          ram_mov,
    output logic          ram_rw,
    output logic [AW-1:0] ram_addr,
    output logic [3:0]    ram_be,
    output logic [31:0]   ram_wdata,
    output logic          stall,
    output logic          done,
    output logic [31:0]   rdata,
    output logic          err,
    output logic [1:0]    err_code
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [1:0]    size_reg;
    logic [1:0]    off_reg;
    logic          uns_reg;

    // Request decode, evaluated on the raw inputs in the IDLE cycle.
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic        misaligned;
    logic        bad_size;

    // Load path, evaluated on ram_rdata with the latched request.
    logic [7:0]  rd_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic        timeout_hit;

    // Lane k sits at bits 31-8k: byte offset 0 is the most significant byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_lane[gi] = ram_rdata[31-8*gi -: 8];
        end
    endgenerate

    assign bad_size   = (size == 2'b11);
    assign misaligned = ((size == 2'b01) && addr[0]) ||
                        ((size == 2'b10) && (addr[1:0] != 2'b00));

    always_comb begin
        be_next    = 4'b0000;
        wdata_next = wdata;
        case (size)
            2'b00: begin
                be_next    = 4'b1000 >> addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_next    = addr[1] ? 4'b0011 : 4'b1100;
                wdata_next = {2{wdata[15:0]}};
            end
            2'b10: begin
                be_next    = 4'b1111;
                wdata_next = wdata;
            end
            default: begin
                be_next    = 4'b0000;
                wdata_next = wdata;
            end
        endcase
    end

    always_comb begin
        byte_sel = rd_lane[off_reg];
        half_sel = off_reg[1] ? ram_rdata[15:0] : ram_rdata[31:16];
        load_val = ram_rdata;
        case (size_reg)
            2'b00:   load_val = uns_reg ? {24'd0, byte_sel}
                                        : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = uns_reg ? {16'd0, half_sel}
                                        : {{16{half_sel[15]}}, half_sel};
            default: load_val = ram_rdata;
        endcase
    end

    // Last permitted ACCESS cycle: ram_mov is high for exactly TIMEOUT cycles.
    assign timeout_hit = (cnt_reg == CW'(TIMEOUT - 1));

    // stall reacts to start in the same cycle so the PC never advances past
    // the memory instruction; it is low in DONE so the core resumes then.
    assign stall = (state_reg == S_ACCESS) || ((state_reg == S_IDLE) && start);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            size_reg  <= 2'b00;
            off_reg   <= 2'b00;
            uns_reg   <= 1'b0;
            ram_mov   <= 1'b0;
            ram_rw    <= 1'b0;
            ram_addr  <= '0;
            ram_be    <= 4'b0000;
            ram_wdata <= 32'd0;
            done      <= 1'b0;
            rdata     <= 32'd0;
            err       <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done     <= 1'b0;
                    err      <= 1'b0;
                    err_code <= 2'b00;
                    if (start) begin
                        ram_rw    <= rw;
                        size_reg  <= size;
                        off_reg   <= addr[1:0];
                        uns_reg   <= unsigned_ld;
                        ram_addr  <= {addr[AW-1:2], 2'b00};
                        ram_be    <= be_next;
                        ram_wdata <= wdata_next;
                        cnt_reg   <= '0;
                        // Faults go straight to DONE and never touch the RAM.
                        if (bad_size) begin
                            state_reg <= S_DONE;
                            done      <= 1'b1;
                            err       <= 1'b1;
                            err_code  <= 2'b11;
                        end else if (misaligned) begin
                            state_reg <= S_DONE;
                            done      <= 1'b1;
                            err       <= 1'b1;
                            err_code  <= 2'b01;
                        end else begin
                            state_reg <= S_ACCESS;
                            ram_mov   <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    // moc wins over a timeout landing in the same cycle.
                    if (ram_moc) begin
                        state_reg <= S_DONE;
                        ram_mov   <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b0;
                        err_code  <= 2'b00;
                        if (ram_rw) begin
                            rdata <= load_val;
                        end
                    end else if (timeout_hit) begin
                        state_reg <= S_DONE;
                        ram_mov   <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        err_code  <= 2'b10;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    err_code  <= 2'b00;
                end
                default: begin
                    state_reg <= S_IDLE;
                    ram_mov   <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_seq.sv
`timescale 1ns/1ps
// Testbench for mem_access_seq: directed load/store requests with a
// behavioural RAM responder and a scoreboard of expected completions.
module tb_mem_access_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        rw;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ram_moc;
    logic [31:0] ram_rdata;
    logic        ram_mov;
    logic        ram_rw;
    logic [31:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic        err;
        logic [1:0]  code;
        logic [31:0] rdata;
        logic        chk_rd;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_access_seq #(.TIMEOUT(16), .AW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rw         (rw),
        .size       (size),
        .unsigned_ld(unsigned_ld),
        .addr       (addr),
        .wdata      (wdata),
        .ram_moc    (ram_moc),
        .ram_rdata  (ram_rdata),
        .ram_mov    (ram_mov),
        .ram_rw     (ram_rw),
        .ram_addr   (ram_addr),
        .ram_be     (ram_be),
        .ram_wdata  (ram_wdata),
        .stall      (stall),
        .done       (done),
        .rdata      (rdata),
        .err        (err),
        .err_code   (err_code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every completion pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check({x.tag, "_err"}, {31'd0, err}, {31'd0, x.err});
                check({x.tag, "_code"}, {30'd0, err_code}, {30'd0, x.code});
                if (x.chk_rd) check({x.tag, "_rdata"}, rdata, x.rdata);
                $display("txn %s: err=%0b code=%0b rdata=0x%08h", x.tag, err, err_code, rdata);
            end
        end
    end

    // moc_lat: ram_moc is raised in the moc_lat-th ram_mov cycle (<=0: never).
    task automatic run_req(input string tag, input logic r, input logic [1:0] sz,
                           input logic u, input logic [31:0] a, input logic [31:0] wd,
                           input int moc_lat, input logic [31:0] word,
                           input logic e_err, input logic [1:0] e_code,
                           input logic [31:0] e_rd, input logic chk_rd,
                           input logic [3:0] e_be, input logic [31:0] e_wd,
                           input int e_mov);
        exp_t x;
        int mov_cnt;
        int stall_cnt;
        bit seen;
        logic [31:0] e_addr;
        mov_cnt   = 0;
        stall_cnt = 0;
        seen      = 0;
        e_addr    = {a[31:2], 2'b00};
        x.tag = tag; x.err = e_err; x.code = e_code; x.rdata = e_rd; x.chk_rd = chk_rd;
        exp_q.push_back(x);

        @(negedge clk);
        rw = r; size = sz; unsigned_ld = u; addr = a; wdata = wd; start = 1'b1;
        #1;
        if (stall) stall_cnt++;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (done) begin
                seen = 1;
                check({tag, "_stall_in_done"}, {31'd0, stall}, 32'd0);
            end else begin
                if (stall) stall_cnt++;
                ram_rdata = $urandom;
                ram_moc   = 1'b0;
                if (ram_mov) begin
                    mov_cnt++;
                    if (mov_cnt == 1) begin
                        check({tag, "_be"}, {28'd0, ram_be}, {28'd0, e_be});
                        check({tag, "_wdata"}, ram_wdata, e_wd);
                        check({tag, "_rw"}, {31'd0, ram_rw}, {31'd0, r});
                        check({tag, "_addr"}, ram_addr, e_addr);
                    end
                    if (mov_cnt == moc_lat) begin
                        ram_moc   = 1'b1;
                        ram_rdata = word;
                    end
                end
                @(negedge clk);
            end
        end
        ram_moc = 1'b0;
        if (!seen) check({tag, "_done_seen"}, 32'd0, 32'd1);
        check({tag, "_mov_cycles"}, mov_cnt, e_mov);
        check({tag, "_stall_cycles"}, stall_cnt, e_mov + 1);
        @(negedge clk);
        check({tag, "_done_width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rw = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
        addr = 32'd0; wdata = 32'd0; ram_moc = 1'b0; ram_rdata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_mov",   {31'd0, ram_mov}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_be",    {28'd0, ram_be}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_code",  {30'd0, err_code}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        //       tag      rw    size  uns  addr          wdata         lat word          err   code   exp rdata     chk   be       ram_wdata     movs
        run_req("lw",     1'b1, 2'b10, 1'b0, 32'h100, 32'h0,         2,  32'hDEADBEEF, 1'b0, 2'b00, 32'hDEADBEEF, 1'b1, 4'b1111, 32'h0,         2);
        run_req("lb",     1'b1, 2'b00, 1'b0, 32'h103, 32'h0,         1,  32'h112233F4, 1'b0, 2'b00, 32'hFFFFFFF4, 1'b1, 4'b0001, 32'h0,         1);
        run_req("lhu",    1'b1, 2'b01, 1'b1, 32'h102, 32'h0,         1,  32'h1122F00D, 1'b0, 2'b00, 32'h0000F00D, 1'b1, 4'b0011, 32'h0,         1);
        run_req("lh",     1'b1, 2'b01, 1'b0, 32'h100, 32'h0,         3,  32'h80011234, 1'b0, 2'b00, 32'hFFFF8001, 1'b1, 4'b1100, 32'h0,         3);
        run_req("lbu",    1'b1, 2'b00, 1'b1, 32'h101, 32'h0,         1,  32'h11A53344, 1'b0, 2'b00, 32'h000000A5, 1'b1, 4'b0100, 32'h0,         1);
        run_req("sh",     1'b0, 2'b01, 1'b0, 32'h202, 32'h0000ABCD,  1,  32'h77777777, 1'b0, 2'b00, 32'h000000A5, 1'b1, 4'b0011, 32'hABCDABCD, 1);
        run_req("sb",     1'b0, 2'b00, 1'b0, 32'h301, 32'h1234565A,  2,  32'h77777777, 1'b0, 2'b00, 32'h000000A5, 1'b1, 4'b0100, 32'h5A5A5A5A, 2);
        run_req("lw_mis", 1'b1, 2'b10, 1'b0, 32'h101, 32'h0,         1,  32'h0,        1'b1, 2'b01, 32'h0,        1'b0, 4'b1111, 32'h0,         0);
        run_req("lh_mis", 1'b1, 2'b01, 1'b0, 32'h103, 32'h0,         1,  32'h0,        1'b1, 2'b01, 32'h0,        1'b0, 4'b0011, 32'h0,         0);
        run_req("bad_sz", 1'b1, 2'b11, 1'b0, 32'h101, 32'h0,         1,  32'h0,        1'b1, 2'b11, 32'h0,        1'b0, 4'b0000, 32'h0,         0);
        run_req("sw_to",  1'b0, 2'b10, 1'b0, 32'h400, 32'h12345678, 0,  32'h0,        1'b1, 2'b10, 32'h0,        1'b0, 4'b1111, 32'h12345678, 16);
        run_req("sw_edge",1'b0, 2'b10, 1'b0, 32'h404, 32'h87654321, 16, 32'h0,        1'b0, 2'b00, 32'h000000A5, 1'b1, 4'b1111, 32'h87654321, 16);

        // Reset in the middle of an access: everything clears, no completion.
        @(negedge clk);
        rw = 1'b1; size = 2'b10; unsigned_ld = 1'b0; addr = 32'h600; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("midrst_mov_before", {31'd0, ram_mov}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_mov",   {31'd0, ram_mov}, 32'd0);
        check("midrst_done",  {31'd0, done}, 32'd0);
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_be",    {28'd0, ram_be}, 32'd0);
        check("midrst_addr",  ram_addr, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_err",   {31'd0, err}, 32'd0);
        $display("txn midrst: reset during ACCESS");
        repeat (3) @(negedge clk);
        check("midrst_no_done", {31'd0, done}, 32'd0);

        run_req("lw_post",1'b1, 2'b10, 1'b0, 32'h500, 32'h0,         1,  32'hCAFEF00D, 1'b0, 2'b00, 32'hCAFEF00D, 1'b1, 4'b1111, 32'h0,         1);

        repeat (2) @(negedge clk);
        check("sb_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
